alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Multi-cycle, handshaked successor to the combinational ALU, parametrised in data width.
//  Adds a carry-flag register for ADC/SBC chaining, iterative multi-bit shifts and a
//  shift-add multiplier. Registered result and flags.
//  Sits between the register file (operand issue) and the control unit (writeback/flags).
// PARAMETERS
//  DATA_BUS_WIDTH  8  operand/result width W (>=4)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operands+op presented
//  in_ready   out  1   block can accept an operation
//  op         in   4   0 ADD,1 ADC,2 SUB,3 SBC,4 AND,5 OR,6 XOR,7 NOT,8 SHL,9 SHR,10 MUL,11 PASS
//  register1  in   W   operand A
//  register2  in   W   operand B / shift amount
//  out_valid  out  1   result/flags valid
//  out_ready  in   1   consumer takes result
//  result     out  W   registered result
//  is_carry   out  1   carry flag register (also carry-in for ADC/SBC)
//  is_zero    out  1   registered (result == 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; result=0, is_carry=0, is_zero=0, out_valid=0, in_ready=1.
//  - FSM IDLE -> (EXEC) -> DONE -> IDLE.
//    - in_ready = (state==IDLE); out_valid = (state==DONE).
//    - Accept on in_valid & in_ready; operands/op latched, inputs then ignored.
//  - Single-cycle ops (0-7, 11, illegal): IDLE -> DONE.
//    - out_valid asserts the cycle after acceptance (latency 1).
//  - SHL/SHR: amount n = register2 (unsigned).
//    - n=0: DONE next cycle, result=A, carry=0.
//    - n>=W: DONE next cycle, result=0, carry=0.
//    - else EXEC shifts 1 bit/cycle, n cycles, zero fill; out_valid at n+1 after accept.
//    - carry = last bit shifted out.
//  - MUL: unsigned shift-add, exactly W EXEC cycles; out_valid at W+1 after accept.
//    - result = low W bits of A*B; carry = |(high W bits).
//  - Arithmetic in W+1 bits:
//    - ADD carry = bit W of A+B.
//    - ADC: A+B+carry_reg.
//    - SUB: A-B, carry = borrow (A<B).
//    - SBC: A-B-carry_reg, carry = borrow.
//  - Logic ops/NOT(A)/PASS(A): carry=0. Illegal op (12-15): result=0, carry=0.
//  - is_zero = (result==0) for every op incl. illegal; result, is_carry, is_zero
//    update only on the DONE-entry edge.
//  - ADC/SBC read carry_reg as it stood at acceptance.
//  - DONE holds result/flags stable until out_ready=1; that edge -> IDLE.
//    - in_ready is therefore high one cycle later; no accept in same cycle as handoff.
//  - result/is_carry/is_zero remain held after handoff until the next DONE entry.
//  - out_ready ignored outside DONE; in_valid ignored outside IDLE.
//  - Reset mid-EXEC/DONE: operation discarded, all state to reset values immediately.
// TESTING
//  1. W=8: ADD 0xFF+0x01 -> result 0x00, carry 1, zero 1, out_valid 1 cycle after accept.
//  2. ADC after (1): 0x10+0x20 -> 0x31 carry 0; then SBC 0x00-0x00 (carry 0) -> 0x00 zero 1;
//     SUB 0x01-0x02 -> 0xFF carry 1.
//  3. SHL 0x81 by 3 -> 0x08, carry 0, out_valid exactly 4 cycles after accept;
//     SHR 0x81 by 1 -> 0x40 carry 1; SHL by 8 -> 0x00 carry 0 in 1 cycle.
//  4. MUL 0x10*0x10 -> 0x00, carry 1, zero 1, latency 9;
//     MUL 0x0C*0x0B -> 0x84 carry 0.
//  5. Backpressure: hold out_ready=0 for 5 cycles -> result/flags/out_valid stable,
//     in_ready=0, in_valid pulses ignored.
//  6. Assert rst_n=0 mid-MUL (EXEC cycle 4) -> outputs to reset values at once;
//     after release, ADD 2+3 -> 0x05 with carry 0.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle handshaked ALU with carry register, iterative shifts and shift-add multiplier
// Single-cycle ops complete on the accept edge; shifts/MUL iterate one step per EXEC cycle.
module alu_seq #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                op,
  input  logic [DATA_BUS_WIDTH-1:0] register1,
  input  logic [DATA_BUS_WIDTH-1:0] register2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic                      is_carry,
  output logic                      is_zero
);
  localparam int W = DATA_BUS_WIDTH;
  localparam logic [W-1:0] W_CNT = W'(W);
  localparam logic [W-1:0] ONE   = W'(1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                         OP_SHL = 4'd8, OP_SHR = 4'd9, OP_MUL = 4'd10, OP_PASS = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   cnt;
  logic [2*W-1:0] acc;

  logic [W:0]     sc_sum;
  logic [W-1:0]   sc_res;
  logic           sc_carry;
  logic           sc_multi;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_nx;
  logic           step_bit;
  logic           fin_carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Result of an op that finishes on its accept edge; sc_multi flags ops that need EXEC.
  always_comb begin
    sc_sum   = '0;
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_multi = 1'b0;
    case (op)
      OP_ADD: sc_sum = {1'b0, register1} + {1'b0, register2};
      OP_ADC: sc_sum = {1'b0, register1} + {1'b0, register2} + {{W{1'b0}}, is_carry};
      OP_SUB: sc_sum = {1'b0, register1} - {1'b0, register2};
      OP_SBC: sc_sum = {1'b0, register1} - {1'b0, register2} - {{W{1'b0}}, is_carry};
      default: sc_sum = '0;
    endcase
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        sc_res   = sc_sum[W-1:0];
        sc_carry = sc_sum[W];
      end
      OP_AND:  sc_res = register1 & register2;
      OP_OR:   sc_res = register1 | register2;
      OP_XOR:  sc_res = register1 ^ register2;
      OP_NOT:  sc_res = ~register1;
      OP_PASS: sc_res = register1;
      OP_SHL, OP_SHR: begin
        if (register2 == '0)        sc_res = register1;
        else if (register2 >= W_CNT) sc_res = '0;
        else                        sc_multi = 1'b1;
      end
      OP_MUL:  sc_multi = 1'b1;
      default: sc_res = '0;
    endcase
  end

  // acc holds the product {hi, lo} for MUL (lo starts as B), or the operand in the low half for shifts.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : '0);
    acc_nx   = acc;
    step_bit = 1'b0;
    case (op_q)
      OP_SHL: begin
        acc_nx   = {acc[2*W-1:W], acc[W-2:0], 1'b0};
        step_bit = acc[W-1];
      end
      OP_SHR: begin
        acc_nx   = {acc[2*W-1:W], 1'b0, acc[W-1:1]};
        step_bit = acc[0];
      end
      default: acc_nx = {mul_sum, acc[W-1:1]};
    endcase
    fin_carry = (op_q == OP_MUL) ? |acc_nx[2*W-1:W] : step_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
      is_carry <= 1'b0;
      is_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op;
          a_q  <= register1;
          if (sc_multi) begin
            state <= EXEC;
            acc   <= {{W{1'b0}}, (op == OP_MUL) ? register2 : register1};
            cnt   <= (op == OP_MUL) ? W_CNT : register2;
          end else begin
            state    <= DONE;
            result   <= sc_res;
            is_carry <= sc_carry;
            is_zero  <= (sc_res == '0);
          end
        end
        EXEC: begin
          acc <= acc_nx;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state    <= DONE;
            result   <= acc_nx[W-1:0];
            is_carry <= fin_carry;
            is_zero  <= (acc_nx[W-1:0] == '0);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
